// File: rtl/fifo_axis_reader.sv
// Drains sync_fifo's read port into an AXI4-Stream master with TLAST every PACKET_LEN beats.
// Optional statistics ports (packet count, sticky underrun) are enabled by FIFO_AXIS_READER_STATS_EN.
module fifo_axis_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int PACKET_LEN = 16
) (
   input  logic                  i_clk,
   input  logic                  i_a_rst_n,
   input  logic                  i_enable,
   output logic                  o_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
   input  logic                  i_fifo_rd_valid,
   input  logic                  i_fifo_empty,
   output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
   output logic                  o_m_axis_tvalid,
   output logic                  o_m_axis_tlast,
   input  logic                  i_m_axis_tready,
`ifdef FIFO_AXIS_READER_STATS_EN
   input  logic                  i_stats_clr,
   output logic [15:0]           o_pkt_count,
   output logic                  o_underrun,
`endif
   output logic                  o_busy
);

   localparam int CW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(PACKET_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN_PKT, DRAIN_BUF} state_e;

   state_e                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic [CW-1:0]         fetch_q, fetch_d, beat_q, beat_d;
   logic                  pop, capture, read_allowed;

   assign pop     = o_m_axis_tvalid && i_m_axis_tready;
   assign capture = i_fifo_rd_valid;

   assign o_m_axis_tvalid = (occ_q != 2'd0);
   assign o_m_axis_tdata  = buf0_q;
   assign o_m_axis_tlast  = o_m_axis_tvalid && (beat_q == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_a_rst_n) begin
      if (!i_a_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (i_enable) state_d = RUN;
         RUN:       if (!i_enable) state_d = (fetch_q == '0) ? DRAIN_BUF : DRAIN_PKT;
         DRAIN_PKT: begin
            if (i_enable) state_d = RUN;
            else if (fetch_q == '0) state_d = DRAIN_BUF;
         end
         DRAIN_BUF: if ((occ_q == 2'd0) && !inflight_q) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // A packet boundary with enable low must not fetch the first word of a packet we won't finish.
   always_comb begin
      read_allowed = 1'b0;
      case (state_q)
         RUN:       read_allowed = i_enable || (fetch_q != '0);
         DRAIN_PKT: read_allowed = (fetch_q != '0);
         default:   read_allowed = 1'b0;
      endcase
      o_fifo_rd_en = read_allowed && !i_fifo_empty
                     && ((occ_q + {1'b0, inflight_q}) < 2'd2);
      o_busy       = (state_q != IDLE) || (occ_q != 2'd0);
   end

   // buf0 is always the head; a pop shifts buf1 forward before any new capture lands.
   always_comb begin
      buf0_d = buf0_q;
      buf1_d = buf1_q;
      occ_d  = occ_q;
      case ({capture, pop})
         2'b11: begin
            if (occ_q == 2'd2) begin
               buf0_d = buf1_q;
               buf1_d = i_fifo_rd_data;
            end else begin
               buf0_d = i_fifo_rd_data;
            end
         end
         2'b01: begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) buf0_d = i_fifo_rd_data;
            else               buf1_d = i_fifo_rd_data;
            occ_d = occ_q + 2'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      fetch_d = fetch_q;
      beat_d  = beat_q;
      if (o_fifo_rd_en) fetch_d = (fetch_q == LAST_IDX) ? '0 : fetch_q + CW'(1);
      if (pop)          beat_d  = (beat_q == LAST_IDX) ? '0 : beat_q + CW'(1);
   end

   always_ff @(posedge i_clk or negedge i_a_rst_n) begin
      if (!i_a_rst_n) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
         fetch_q    <= '0;
         beat_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= o_fifo_rd_en;
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         fetch_q    <= fetch_d;
         beat_q     <= beat_d;
      end
   end

`ifdef FIFO_AXIS_READER_STATS_EN
   logic [15:0] pkt_count_q;
   logic        underrun_q;
   logic        underrun_event;

   assign underrun_event = ((state_q == RUN) || (state_q == DRAIN_PKT)) && (beat_q != '0)
                           && (occ_q == 2'd0) && i_fifo_empty;

   always_ff @(posedge i_clk or negedge i_a_rst_n) begin
      if (!i_a_rst_n) begin
         pkt_count_q <= 16'd0;
         underrun_q  <= 1'b0;
      end else if (i_stats_clr) begin
         pkt_count_q <= 16'd0;
         underrun_q  <= 1'b0;
      end else begin
         if (pop && o_m_axis_tlast) pkt_count_q <= pkt_count_q + 16'd1;
         if (underrun_event)        underrun_q  <= 1'b1;
      end
   end

   assign o_pkt_count = pkt_count_q;
   assign o_underrun  = underrun_q;
`endif

endmodule
